// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the GPR write-side arbiter.
package reg_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries for long-latency results.
// With REG_WB_FORWARD_EN it also offers a youngest-match search by destination register.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_entry_t             push_data,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty
`ifdef REG_WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] search_wa,
    output logic                  search_hit,
    output logic [DATA_W-1:0]     search_wd
`endif
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

`ifdef REG_WB_FORWARD_EN
    logic [AW:0] count;
    assign count = wr_ptr - rd_ptr;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        search_hit = 1'b0;
        search_wd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < count) && (mem[rd_ptr[AW-1:0] + AW'(i)].wa == search_wa)) begin
                search_hit = 1'b1;
                search_wd  = mem[rd_ptr[AW-1:0] + AW'(i)].wd;
            end
        end
    end
`endif

endmodule

// File: rtl/reg_wb_arbiter.sv
// GPR write-port arbiter: pipeline write-back beats buffered long-latency results.
// Optional REG_WB_FORWARD_EN adds a combinational forwarding lookup (fwd_ra/fwd_hit/fwd_data).
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_wa,
    input  logic [DATA_W-1:0]     pipe_wd,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_wa,
    input  logic [DATA_W-1:0]     lu_wd,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_wa,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  wb_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0]     rf_wd
`ifdef REG_WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] fwd_ra,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    localparam int                CNT_W     = $clog2(STARVE_MAX + 1);
    localparam logic [NUM_REGS-1:0] BUSY_MASK = ~NUM_REGS'(1);

    wb_entry_t             head;
    wb_entry_t             push_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  pipe_sel;
    logic                  sel_we_p0;
    logic [REG_ADDR_W-1:0] sel_wa_p0;
    logic [DATA_W-1:0]     sel_wd_p0;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   clr_vec;
    logic [CNT_W-1:0]      starve_cnt;
    logic [CNT_W-1:0]      starve_nxt;
`ifdef REG_WB_FORWARD_EN
    logic                  fifo_hit;
    logic [DATA_W-1:0]     fifo_hit_wd;
`endif

    assign lu_ready  = rst_n && !fifo_full;
    assign push      = lu_valid && lu_ready && (lu_wa != '0);
    assign push_data = '{wa: lu_wa, wd: lu_wd};
    assign pipe_sel  = pipe_we && (pipe_wa != '0);
    assign pop       = !pipe_sel && !fifo_empty;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
`ifdef REG_WB_FORWARD_EN
        ,
        .search_wa (fwd_ra),
        .search_hit(fifo_hit),
        .search_wd (fifo_hit_wd)
`endif
    );

    // Stage p0: write-port selection, registered into rf_* at the edge.
    always_comb begin
        sel_we_p0 = pipe_sel || pop;
        sel_wa_p0 = head.wa;
        sel_wd_p0 = head.wd;
        if (pipe_sel) begin
            sel_wa_p0 = pipe_wa;
            sel_wd_p0 = pipe_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= sel_we_p0;
            if (sel_we_p0) begin
                rf_wa <= sel_wa_p0;
                rf_wd <= sel_wd_p0;
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid) set_vec[iss_wa] = 1'b1;
        if (pop)       clr_vec[head.wa] = 1'b1;
    end

    // Set is OR-ed after the clear so an issue on the retiring register wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= ((busy & ~clr_vec) | set_vec) & BUSY_MASK;
    end

    always_comb begin
        if (fifo_empty || pop)                       starve_nxt = '0;
        else if (starve_cnt == CNT_W'(STARVE_MAX))   starve_nxt = starve_cnt;
        else                                         starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            wb_stall   <= (starve_nxt == CNT_W'(STARVE_MAX));
        end
    end

`ifdef REG_WB_FORWARD_EN
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_ra != '0) begin
            if (rf_we && (rf_wa == fwd_ra)) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_wd;
            end else if (fifo_hit) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_hit_wd;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_pipe_to_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(pipe_we && (pipe_wa != '0) && busy[pipe_wa]));
    a_pipe_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
        !(pipe_we && wb_stall));
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: scoreboard of expected register-file writes
// plus per-scenario direct checks of handshake, scoreboard bits and starvation.
`timescale 1ns/1ps
module tb_reg_wb_arbiter;
    import reg_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_wa;
    logic [31:0] lu_wd;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic [31:0] busy;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
`ifdef REG_WB_FORWARD_EN
    logic [4:0]  fwd_ra;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    reg_wb_arbiter #(
        .FIFO_DEPTH(4),
        .STARVE_MAX(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pipe_we  (pipe_we),
        .pipe_wa  (pipe_wa),
        .pipe_wd  (pipe_wd),
        .lu_valid (lu_valid),
        .lu_ready (lu_ready),
        .lu_wa    (lu_wa),
        .lu_wd    (lu_wd),
        .iss_valid(iss_valid),
        .iss_wa   (iss_wa),
        .busy     (busy),
        .wb_stall (wb_stall),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd)
`ifdef REG_WB_FORWARD_EN
        ,
        .fwd_ra   (fwd_ra),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    int        n_cmp = 0;
    int        n_err = 0;
    wb_entry_t exp_q[$];
    wb_entry_t sb_e;

    // Every register-file write must match the next expected write, in order.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_write: got r%0d=%h, required no write", rf_wa, rf_wd);
            end else begin
                sb_e = exp_q.pop_front();
                if (rf_wa !== sb_e.wa || rf_wd !== sb_e.wd) begin
                    n_err++;
                    $display("FAIL sb_write: got r%0d=%h, required r%0d=%h", rf_wa, rf_wd, sb_e.wa, sb_e.wd);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
        lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
        iss_valid = 1'b0; iss_wa = '0;
`ifdef REG_WB_FORWARD_EN
        fwd_ra = '0;
`endif
    endtask

    task automatic exp_write(input logic [4:0] wa, input logic [31:0] wd);
        exp_q.push_back('{wa: wa, wd: wd});
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b, required 0", rf_we); end
        n_cmp++; if (rf_wa !== 5'd0) begin n_err++; $display("FAIL reset_rf_wa: got %0d, required 0", rf_wa); end
        n_cmp++; if (rf_wd !== 32'd0) begin n_err++; $display("FAIL reset_rf_wd: got %h, required 0", rf_wd); end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL reset_busy: got %h, required 0", busy); end
        n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL reset_wb_stall: got %b, required 0", wb_stall); end
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL reset_lu_ready: got %b, required 0", lu_ready); end
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_lu_ready: got %b, required 1", lu_ready); end
    endtask

    task automatic test_single();
        iss_valid = 1'b1; iss_wa = 5'd5;
        tick();
        iss_valid = 1'b0;
        n_cmp++; if (busy !== 32'h0000_0020) begin n_err++; $display("FAIL single_busy_set: got %h, required 00000020", busy); end
        lu_valid = 1'b1; lu_wa = 5'd5; lu_wd = 32'hDEAD_BEEF;
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL single_lu_ready: got %b, required 1", lu_ready); end
        exp_write(5'd5, 32'hDEAD_BEEF);
        tick();
        lu_valid = 1'b0;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_latency_early: got rf_we=%b, required 0", rf_we); end
        n_cmp++; if (busy !== 32'h0000_0020) begin n_err++; $display("FAIL single_busy_hold: got %h, required 00000020", busy); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL single_rf: got we=%b r%0d=%h, required we=1 r5=deadbeef", rf_we, rf_wa, rf_wd);
        end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL single_busy_clear: got %h, required 0", busy); end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_rf_idle: got rf_we=%b, required 0", rf_we); end
    endtask

    task automatic test_reset_burst();
        for (int i = 1; i <= 3; i++) begin
            iss_valid = 1'b1; iss_wa = 5'(i);
            tick();
        end
        iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'b1; pipe_wa = 5'd20; pipe_wd = 32'hC00 + i;
            exp_write(5'd20, 32'hC00 + i);
            lu_valid = 1'b1; lu_wa = 5'(1 + i); lu_wd = 32'hD00 + i;
            tick();
        end
        lu_valid = 1'b0; pipe_we = 1'b0;
        n_cmp++; if (busy !== 32'h0000_000E) begin n_err++; $display("FAIL burst_busy: got %h, required 0000000e", busy); end
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL burst_lu_ready: got %b, required 1", lu_ready); end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
            n_err++; $display("FAIL burst_reset_rf: got we=%b r%0d=%h, required all 0", rf_we, rf_wa, rf_wd);
        end
        n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL burst_reset_busy: got %h, required 0", busy); end
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL burst_reset_lu_ready: got %b, required 0", lu_ready); end
        n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL burst_reset_wb_stall: got %b, required 0", wb_stall); end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (lu_ready !== 1'b1 || busy !== 32'd0) begin
            n_err++; $display("FAIL burst_release: got lu_ready=%b busy=%h, required 1 and 0", lu_ready, busy);
        end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL burst_entries_lost: got rf_we=%b, required 0", rf_we); end
    endtask

    task automatic test_priority();
        lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'h11;
        tick();
        lu_valid = 1'b0;
        pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h22;
        exp_write(5'd3, 32'h22);
        exp_write(5'd7, 32'h11);
        tick();
        pipe_we = 1'b0;
        n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h22) begin
            n_err++; $display("FAIL prio_pipe_first: got we=%b r%0d=%h, required r3=22", rf_we, rf_wa, rf_wd);
        end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h11) begin
            n_err++; $display("FAIL prio_fifo_next: got we=%b r%0d=%h, required r7=11", rf_we, rf_wa, rf_wd);
        end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL prio_idle: got rf_we=%b, required 0", rf_we); end
    endtask

    task automatic test_r0();
        lu_valid = 1'b1; lu_wa = 5'd0; lu_wd = 32'h55;
        n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL r0_lu_ready: got %b, required 1", lu_ready); end
        tick();
        lu_wa = 5'd12; lu_wd = 32'h33;
        pipe_we = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'h66;
        tick();
        lu_valid = 1'b0;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_no_write: got rf_we=%b r%0d, required 0", rf_we, rf_wa); end
        exp_write(5'd12, 32'h33);
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 5'd12) begin
            n_err++; $display("FAIL r0_pipe_no_block: got we=%b r%0d, required we=1 r12", rf_we, rf_wa);
        end
        pipe_we = 1'b0;
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_idle: got rf_we=%b, required 0", rf_we); end
    endtask

    task automatic test_full();
        int guard;
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_wa = 5'd20; pipe_wd = 32'h900 + i;
            exp_write(5'd20, 32'h900 + i);
            lu_valid = 1'b1; lu_wa = 5'(16 + i); lu_wd = 32'hF00 + i;
            n_cmp++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d: got %b, required 1", i, lu_ready); end
            tick();
        end
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL full_not_ready: got %b, required 0", lu_ready); end
        lu_wa = 5'd24; lu_wd = 32'hF04;
        pipe_wd = 32'h904;
        exp_write(5'd20, 32'h904);
        tick();
        n_cmp++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL full_held: got %b, required 0", lu_ready); end
        pipe_we = 1'b0;
        for (int i = 0; i < 4; i++) exp_write(5'(16 + i), 32'hF00 + i);
        exp_write(5'd24, 32'hF04);
        tick();
        n_cmp++; if (lu_ready !== 1'b1 || rf_wa !== 5'd16) begin
            n_err++; $display("FAIL full_first_pop: got lu_ready=%b r%0d, required 1 and r16", lu_ready, rf_wa);
        end
        tick();
        lu_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_starve();
        lu_valid = 1'b1; lu_wa = 5'd25; lu_wd = 32'h77;
        tick();
        lu_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            pipe_we = 1'b1; pipe_wa = 5'd20; pipe_wd = 32'hA00 + k;
            exp_write(5'd20, 32'hA00 + k);
            tick();
            if (k == 7) begin
                n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL starve_early: got %b, required 0", wb_stall); end
            end
        end
        n_cmp++; if (wb_stall !== 1'b1) begin n_err++; $display("FAIL starve_stall: got %b, required 1", wb_stall); end
        pipe_we = 1'b0;
        exp_write(5'd25, 32'h77);
        tick();
        n_cmp++; if (wb_stall !== 1'b0 || rf_wa !== 5'd25 || rf_we !== 1'b1) begin
            n_err++; $display("FAIL starve_release: got stall=%b we=%b r%0d, required 0 1 r25", wb_stall, rf_we, rf_wa);
        end
        tick();
    endtask

`ifdef REG_WB_FORWARD_EN
    task automatic test_forward();
        int guard;
        pipe_we = 1'b1; pipe_wa = 5'd20; pipe_wd = 32'hB00;
        exp_write(5'd20, 32'hB00);
        lu_valid = 1'b1; lu_wa = 5'd9; lu_wd = 32'hA;
        tick();
        pipe_wd = 32'hB01;
        exp_write(5'd20, 32'hB01);
        lu_wd = 32'hB;
        tick();
        lu_valid = 1'b0;
        pipe_wd = 32'hB02;
        exp_write(5'd20, 32'hB02);
        fwd_ra = 5'd9;
        #1;
        n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin
            n_err++; $display("FAIL fwd_youngest: got hit=%b data=%h, required 1 0000000b", fwd_hit, fwd_data);
        end
        fwd_ra = 5'd20;
        #1;
        n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB01) begin
            n_err++; $display("FAIL fwd_rf: got hit=%b data=%h, required 1 00000b01", fwd_hit, fwd_data);
        end
        fwd_ra = 5'd0;
        #1;
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_r0: got hit=%b, required 0", fwd_hit); end
        tick();
        pipe_we = 1'b0;
        exp_write(5'd9, 32'hA);
        exp_write(5'd9, 32'hB);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fwd_drain: got %0d pending, required 0", exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reset_burst();
        test_priority();
        test_r0();
        test_full();
        test_starve();
`ifdef REG_WB_FORWARD_EN
        test_forward();
`endif
        tick();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
